// File: rtl/cdc_hs_arbiter.sv
// Round-robin source-side arbiter sharing one 4-phase handshake CDC channel
// among N_REQ requesters; counts completed transfers and flags lost acknowledges.
module cdc_hs_arbiter #(
  parameter int  N_REQ   = 4,
  parameter int  DATA_W  = 8,
  parameter int  TIMEOUT = 8,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ack,
  output logic                      cdc_valid,
  output logic [ID_W+DATA_W-1:0]    cdc_data,
  input  logic                      cdc_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic [15:0]               xfer_cnt,
  output logic                      err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  state_e             state_r;
  state_e             state_nxt_s;
  logic [CNT_W-1:0]   tmo_cnt_r;
  logic [CNT_W-1:0]   tmo_cnt_nxt_s;
  logic [ID_W-1:0]    last_grant_r;
  logic [ID_W-1:0]    cand_s;
  logic [ID_W-1:0]    win_id_s;
  logic               win_found_s;
  logic [DATA_W-1:0]  win_data_s;
  logic               issue_s;
  logic               xfer_done_s;
  logic               tmo_hit_s;

  // Round-robin search starting at the requester after the last grant
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    cand_s      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s = ID_W'((int'(last_grant_r) + i) % N_REQ);
      if (!win_found_s && req_valid[cand_s]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Payload mux for the selected requester
  always_comb begin
    win_data_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_id_s == ID_W'(k)) begin
        win_data_s = req_data[k*DATA_W +: DATA_W];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  // Next-state and registered-output enables
  always_comb begin
    state_nxt_s   = state_r;
    tmo_cnt_nxt_s = tmo_cnt_r;
    issue_s       = 1'b0;
    xfer_done_s   = 1'b0;
    tmo_hit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        // busy still high means the previous handshake has not unwound yet
        if (!cdc_busy && win_found_s) begin
          state_nxt_s = ISSUE;
          issue_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s   = WAIT_HI;
        tmo_cnt_nxt_s = '0;
      end
      WAIT_HI: begin
        if (cdc_busy) begin
          state_nxt_s   = WAIT_LO;
          tmo_cnt_nxt_s = '0;
        end else if (tmo_cnt_r == CNT_W'(TIMEOUT - 2)) begin
          state_nxt_s   = IDLE;
          tmo_cnt_nxt_s = '0;
          tmo_hit_s     = 1'b1;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!cdc_busy) begin
          state_nxt_s = IDLE;
          xfer_done_s = 1'b1;
        end else begin
          state_nxt_s = WAIT_LO;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        tmo_cnt_nxt_s = '0;
      end
    endcase
  end

  // FSM state and timeout counter
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_r   <= IDLE;
      tmo_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
    end
  end

  // Registered outputs, grant history and transfer statistics
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cdc_valid    <= 1'b0;
      cdc_data     <= '0;
      req_ack      <= '0;
      grant_id     <= '0;
      last_grant_r <= ID_W'(N_REQ - 1);
      xfer_cnt     <= 16'd0;
      err_timeout  <= 1'b0;
    end else begin
      cdc_valid <= issue_s;
      req_ack   <= issue_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_id_s) : '0;
      if (issue_s) begin
        cdc_data     <= {win_id_s, win_data_s};
        grant_id     <= win_id_s;
        last_grant_r <= win_id_s;
      end
      if (xfer_done_s) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      if (tmo_hit_s) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Directed bench for cdc_hs_arbiter with a scoreboard of expected issues and a
// behavioural 4-phase synchronizer (3:7 clock ratio) for the end-to-end run.
module tb_cdc_hs_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 8;
  localparam int W       = ID_W + DATA_W;

  logic                    i_clk   = 1'b0;
  logic                    dst_clk = 1'b0;
  logic                    i_rstn  = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ*DATA_W-1:0] req_data  = '0;
  logic [N_REQ-1:0]        req_ack;
  logic                    cdc_valid;
  logic [W-1:0]            cdc_data;
  logic                    cdc_busy;
  logic [ID_W-1:0]         grant_id;
  logic [15:0]             xfer_cnt;
  logic                    err_timeout;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] src_exp[$];
  logic [W-1:0] dst_exp[$];
  logic [W-1:0] dst_obs[$];

  // simple busy model: busy_len cycles of busy after each issue, or forced
  int   busy_len   = 6;
  int   bcnt       = 0;
  logic busy_force = 1'b0;
  logic sync_mode  = 1'b0;

  // 4-phase synchronizer model
  logic         s_req, s_busy, ack_s1, ack_s2;
  logic         req_d1, req_d2, d_ack, o_valid;
  logic [W-1:0] s_data, o_data;

  assign cdc_busy = sync_mode ? s_busy : ((bcnt != 0) | busy_force);

  always #3 i_clk = ~i_clk;
  always #7 dst_clk = ~dst_clk;

  cdc_hs_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .cdc_valid   (cdc_valid),
    .cdc_data    (cdc_data),
    .cdc_busy    (cdc_busy),
    .grant_id    (grant_id),
    .xfer_cnt    (xfer_cnt),
    .err_timeout (err_timeout)
  );

  always @(posedge i_clk) begin
    if (!i_rstn) bcnt <= 0;
    else if (!sync_mode && cdc_valid === 1'b1 && busy_len != 0) bcnt <= busy_len;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  always @(posedge i_clk) begin
    if (!i_rstn) begin
      s_req <= 1'b0; s_busy <= 1'b0; ack_s1 <= 1'b0; ack_s2 <= 1'b0; s_data <= '0;
    end else begin
      ack_s1 <= d_ack;
      ack_s2 <= ack_s1;
      if (sync_mode && !s_busy && cdc_valid === 1'b1) begin
        s_data <= cdc_data; s_req <= 1'b1; s_busy <= 1'b1;
      end else if (s_req && ack_s2) begin
        s_req <= 1'b0;
      end else if (!s_req && s_busy && !ack_s2) begin
        s_busy <= 1'b0;
      end
    end
  end

  always @(posedge dst_clk) begin
    if (!i_rstn) begin
      req_d1 <= 1'b0; req_d2 <= 1'b0; d_ack <= 1'b0; o_valid <= 1'b0; o_data <= '0;
    end else begin
      req_d1  <= s_req;
      req_d2  <= req_d1;
      o_valid <= 1'b0;
      if (req_d2 && !d_ack) begin
        d_ack <= 1'b1; o_valid <= 1'b1; o_data <= s_data;
      end else if (!req_d2 && d_ack) begin
        d_ack <= 1'b0;
      end
    end
  end

  always @(negedge dst_clk) begin
    if (i_rstn && o_valid) dst_obs.push_back(o_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // one cycle: compare any issue against the scoreboard head
  task automatic step(output bit iss);
    logic [W-1:0] e;
    @(negedge i_clk);
    iss = 1'b0;
    if (i_rstn && cdc_valid === 1'b1) begin
      iss = 1'b1;
      check("sb_has_entry", 32'(src_exp.size() != 0), 32'd1);
      if (src_exp.size() != 0) begin
        e = src_exp.pop_front();
        check("cdc_data", 32'(cdc_data), 32'(e));
        check("req_ack_onehot", 32'(req_ack), 32'd1 << e[W-1 -: ID_W]);
        check("grant_id", 32'(grant_id), 32'(e[W-1 -: ID_W]));
      end
    end else if (i_rstn && req_ack !== '0) begin
      check("req_ack_idle", 32'(req_ack), 32'd0);
    end
  endtask

  task automatic wait_issue(input string tag, output int n);
    bit iss;
    n = 0; iss = 1'b0;
    while (!iss && n < 300) begin step(iss); n++; end
    check({tag, "_issued"}, 32'(iss), 32'd1);
  endtask

  task automatic wait_xfer(input string tag, input logic [15:0] target, output int n);
    bit iss;
    n = 0;
    while (xfer_cnt !== target && n < 4000) begin step(iss); n++; end
    check({tag, "_xfer"}, 32'(xfer_cnt), 32'(target));
  endtask

  task automatic push(input int k, input logic [DATA_W-1:0] d);
    req_data[k*DATA_W +: DATA_W] = d;
    src_exp.push_back({ID_W'(k), d});
  endtask

  task automatic do_reset();
    bit iss;
    i_rstn = 1'b0; req_valid = '0; busy_force = 1'b0;
    repeat (6) step(iss);
    i_rstn = 1'b1;
  endtask

  initial begin
    int n;
    int k;
    bit iss;
    logic [DATA_W-1:0] d;

    // reset values
    repeat (3) @(negedge i_clk);
    check("rst_cdc_valid", 32'(cdc_valid), 32'd0);
    check("rst_cdc_data", 32'(cdc_data), 32'd0);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    i_rstn = 1'b1;

    // single requester, busy high for 6 cycles after the issue
    busy_len = 6; push(2, 8'hA5); req_valid = 4'b0100;
    wait_issue("t1", n);
    check("t1_latency", 32'(n), 32'd1);
    step(iss);
    check("t1_single_cycle", 32'(iss), 32'd0);
    req_valid = '0;
    wait_xfer("t1", 16'd1, n);
    check("t1_xfer_cycles", 32'(n), 32'd7);
    check("t1_data_hold", 32'(cdc_data), 32'h2A5);

    // fairness: all four pending for 8 transfers -> 0,1,2,3,0,1,2,3
    do_reset();
    busy_len = 2;
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < N_REQ; j++) push(j, 8'h30 + 8'(j));
    req_valid = 4'b1111;
    wait_xfer("t2", 16'd8, n);
    req_valid = '0;
    check("t2_all_granted", 32'(src_exp.size()), 32'd0);

    // busy high blocks arbitration
    busy_force = 1'b1; busy_len = 3; push(0, 8'h5C); req_valid = 4'b0001;
    for (int j = 0; j < 5; j++) begin
      step(iss);
      check("t3_hold", 32'(iss), 32'd0);
    end
    busy_force = 1'b0;
    step(iss);
    check("t3_release", 32'(iss), 32'd1);
    step(iss);
    req_valid = '0;
    wait_xfer("t3", 16'd9, n);

    // timeout: busy never rises
    busy_len = 0; push(1, 8'hC3); req_valid = 4'b0010;
    wait_issue("t4", n);
    for (int j = 1; j <= TIMEOUT; j++) begin
      step(iss);
      if (j == 1) req_valid = '0;
      check((j < TIMEOUT) ? "t4_err_early" : "t4_err_set", 32'(err_timeout), 32'(j == TIMEOUT));
    end
    check("t4_xfer_unchanged", 32'(xfer_cnt), 32'd9);
    busy_len = 3; push(2, 8'h7E); req_valid = 4'b0100;
    wait_issue("t4b", n);
    check("t4_next_latency", 32'(n), 32'd1);
    step(iss);
    req_valid = '0;
    wait_xfer("t4b", 16'd10, n);
    check("t4_err_sticky", 32'(err_timeout), 32'd1);

    // reset while waiting for busy to fall
    busy_len = 20; push(0, 8'h11); req_valid = 4'b0001;
    wait_issue("t5", n);
    step(iss);
    req_valid = '0;
    repeat (3) step(iss);
    i_rstn = 1'b0;
    step(iss);
    check("t5_rst_cdc_valid", 32'(cdc_valid), 32'd0);
    check("t5_rst_cdc_data", 32'(cdc_data), 32'd0);
    check("t5_rst_req_ack", 32'(req_ack), 32'd0);
    check("t5_rst_grant_id", 32'(grant_id), 32'd0);
    check("t5_rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("t5_rst_err", 32'(err_timeout), 32'd0);
    i_rstn = 1'b1; busy_len = 3;
    req_data[3*DATA_W +: DATA_W] = 8'h33;
    push(1, 8'h22); req_valid = 4'b1010;
    wait_issue("t5b", n);
    check("t5_first_grant", 32'(grant_id), 32'd1);
    step(iss);
    req_valid = '0;
    wait_xfer("t5b", 16'd1, n);

    // end-to-end through the synchronizer model
    sync_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      k = $urandom_range(0, N_REQ - 1);
      d = 8'($urandom);
      push(k, d);
      dst_exp.push_back({ID_W'(k), d});
      req_valid = 4'b0001 << k;
      wait_issue("t6", n);
      step(iss);
      req_valid = '0;
    end
    wait_xfer("t6", 16'd50, n);
    repeat (10) step(iss);
    check("t6_count", 32'(dst_obs.size()), 32'd50);
    for (int i = 0; i < dst_obs.size() && i < dst_exp.size(); i++)
      check("t6_word", 32'(dst_obs[i]), 32'(dst_exp[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
